// File: rtl/score_plotter_pkg.sv
// Shared constants, state encoding and helpers for the score plotter and its
// pixel mapper.
package score_plotter_pkg;

  localparam int GLYPH_W    = 8;
  localparam int GLYPH_H    = 8;
  localparam int MAX_SCORE  = 999;
  localparam int MAX_DIGITS = 3;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t LOAD   = 3'd1;
  localparam state_t CLEAR  = 3'd2;
  localparam state_t DRAW   = 3'd3;
  localparam state_t FINISH = 3'd4;

  function automatic logic [9:0] clamp_score(input logic [9:0] v);
    return (v > 10'(MAX_SCORE)) ? 10'(MAX_SCORE) : v;
  endfunction

  function automatic logic [1:0] digit_count(input logic [9:0] v);
    if (v > 10'd99) return 2'd3;
    else if (v > 10'd9) return 2'd2;
    else return 2'd1;
  endfunction

endpackage

// File: rtl/score_pixel_map.sv
// Maps a glyph bit index and digit slot to a screen pixel. Bit 7 of each glyph
// row is its leftmost pixel.
module score_pixel_map
  import score_plotter_pkg::*;
#(
  parameter logic [7:0] X0    = 8'd4,
  parameter logic [6:0] Y0    = 7'd4,
  parameter int         PITCH = 9
) (
  input  logic [5:0] offset,
  input  logic [1:0] digit,
  output logic [7:0] x,
  output logic [6:0] y
);

  logic [7:0] col;

  assign col = 8'(GLYPH_W - 1) - {5'd0, offset[2:0]};
  assign x   = X0 + ({6'd0, digit} * 8'(PITCH)) + col;
  assign y   = Y0 + {4'd0, offset[5:3]};

endmodule

// File: rtl/score_plotter.sv
// Sequences a score redraw: clears the score region, then converts the digit
// renderer's serial bit stream into VGA pixel writes.
module score_plotter
  import score_plotter_pkg::*;
#(
  parameter logic [7:0] X0    = 8'd4,
  parameter logic [6:0] Y0    = 7'd4,
  parameter int         PITCH = 9,
  parameter logic [2:0] FG    = 3'b111,
  parameter logic [2:0] BG    = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] score,
  input  logic       bus_grant,
  output logic       busy,
  output logic       finished,
  output logic       r_ld_en,
  output logic       r_draw_en,
  output logic       r_pause,
  output logic [9:0] r_score,
  input  logic       r_done,
  input  logic       r_cur_bit,
  input  logic [5:0] r_offset,
  input  logic [1:0] r_digit_offset,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);

  localparam logic [7:0] CxLast = 8'(MAX_DIGITS * PITCH - 1);
  localparam logic [2:0] CyLast = 3'(GLYPH_H - 1);

  state_t     state;
  logic [9:0] sc;
  logic [1:0] ndig;
  logic [7:0] cx;
  logic [2:0] cy;
  logic       cap_valid;
  logic [5:0] cap_o;
  logic [1:0] cap_d;
  logic       advance;
  logic [9:0] sc_in;
  logic [7:0] map_x;
  logic [6:0] map_y;

  assign sc_in   = clamp_score(score);
  // Digits beyond ndig are never captured, so a renderer that walks extra
  // slots cannot spill pixels past the rendered number.
  assign advance = (state == DRAW) & bus_grant & ~r_done & (r_digit_offset < ndig);

  score_pixel_map #(
    .X0    (X0),
    .Y0    (Y0),
    .PITCH (PITCH)
  ) u_map (
    .offset (cap_o),
    .digit  (cap_d),
    .x      (map_x),
    .y      (map_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sc        <= '0;
      ndig      <= '0;
      cx        <= '0;
      cy        <= '0;
      cap_valid <= 1'b0;
      cap_o     <= '0;
      cap_d     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            sc    <= sc_in;
            ndig  <= digit_count(sc_in);
          end
        end
        LOAD: begin
          state <= CLEAR;
          cx    <= '0;
          cy    <= '0;
        end
        CLEAR: begin
          if (bus_grant) begin
            if (cx == CxLast) begin
              cx <= '0;
              cy <= cy + 3'd1;
              if (cy == CyLast) state <= DRAW;
            end else begin
              cx <= cx + 8'd1;
            end
          end
        end
        DRAW: begin
          // The captured index waits for a granted cycle, since its bit
          // arrives one cycle after the advance.
          if (advance) begin
            cap_o     <= r_offset;
            cap_d     <= r_digit_offset;
            cap_valid <= 1'b1;
          end else if (bus_grant) begin
            cap_valid <= 1'b0;
          end
          if (r_done && !cap_valid) state <= FINISH;
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    finished  = (state == FINISH);
    r_ld_en   = (state == LOAD);
    r_draw_en = (state == DRAW);
    r_pause   = ~bus_grant;
    r_score   = sc;
    plot      = 1'b0;
    x         = '0;
    y         = '0;
    colour    = '0;
    case (state)
      CLEAR: begin
        plot   = bus_grant;
        x      = X0 + cx;
        y      = Y0 + {4'd0, cy};
        colour = BG;
      end
      DRAW: begin
        plot   = cap_valid & bus_grant;
        x      = map_x;
        y      = map_y;
        colour = r_cur_bit ? FG : BG;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_score_plotter.sv
// Directed bench for score_plotter with a behavioural digit renderer and a
// shadow framebuffer of the score region.
module tb_score_plotter;

  logic       clk = 1'b0;
  logic       reset, start, bus_grant;
  logic [9:0] score;
  logic       busy, finished, r_ld_en, r_draw_en, r_pause;
  logic [9:0] r_score;
  logic       r_done, r_cur_bit;
  logic [5:0] r_offset;
  logic [1:0] r_digit_offset;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  score_plotter dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .score          (score),
    .bus_grant      (bus_grant),
    .busy           (busy),
    .finished       (finished),
    .r_ld_en        (r_ld_en),
    .r_draw_en      (r_draw_en),
    .r_pause        (r_pause),
    .r_score        (r_score),
    .r_done         (r_done),
    .r_cur_bit      (r_cur_bit),
    .r_offset       (r_offset),
    .r_digit_offset (r_digit_offset),
    .x              (x),
    .y              (y),
    .colour         (colour),
    .plot           (plot)
  );

  function automatic logic font_bit(input int d, input int r, input int b);
    logic [63:0] g;
    case (d)
      0: g = 64'h3C666E7666663C00;
      1: g = 64'h183818181818_7E00;
      2: g = 64'h3C66060C30607E00;
      3: g = 64'h3C66061C06663C00;
      4: g = 64'h0C1C3C6C7E0C0C00;
      5: g = 64'h7E607C0606663C00;
      6: g = 64'h3C607C6666663C00;
      7: g = 64'h7E060C1830303000;
      8: g = 64'h3C66663C66663C00;
      9: g = 64'h3C66663E060C3800;
      default: g = '0;
    endcase
    return g[56 - 8 * r + b];
  endfunction

  function automatic int ndig_of(input int v);
    return (v > 99) ? 3 : (v > 9) ? 2 : 1;
  endfunction

  // idx 0 is the leftmost digit of the number.
  function automatic int digit_of(input int v, input int nd, input int idx);
    int pos = nd - 1 - idx;
    int p   = (pos == 2) ? 100 : (pos == 1) ? 10 : 1;
    return (v / p) % 10;
  endfunction

  // Renderer model: registered bit one cycle after each advance.
  int m_score, m_ndig;
  always @(posedge clk) begin
    if (reset) begin
      r_offset <= '0; r_digit_offset <= '0; r_done <= 1'b0; r_cur_bit <= 1'b0;
      m_score <= 0; m_ndig <= 1;
    end else if (r_ld_en) begin
      m_score <= int'(r_score); m_ndig <= ndig_of(int'(r_score));
      r_offset <= '0; r_digit_offset <= '0; r_done <= 1'b0;
    end else if (r_draw_en && !r_pause && !r_done) begin
      r_cur_bit <= font_bit(digit_of(m_score, m_ndig, int'(r_digit_offset)),
                            int'(r_offset[5:3]), int'(r_offset[2:0]));
      if (r_offset == 6'd63) begin
        r_offset <= '0;
        if (int'(r_digit_offset) == m_ndig - 1) r_done <= 1'b1;
        else r_digit_offset <= r_digit_offset + 2'd1;
      end else begin
        r_offset <= r_offset + 6'd1;
      end
    end
  end

  logic [2:0] fb [0:31][0:15];
  int wr [0:31][0:15];
  int clear_cnt, draw_cnt, clear_bad, oor, pause_bad, fin_cnt, busy_cyc;
  int cyc = 0, en_cyc, first_plot_cyc;

  always @(negedge clk) begin
    cyc++;
    if (r_pause !== ~bus_grant) pause_bad++;
    if (busy === 1'b1) busy_cyc++;
    if (finished === 1'b1) fin_cnt++;
    if (r_draw_en === 1'b1 && en_cyc < 0) en_cyc = cyc;
    if (plot === 1'b1) begin
      if (x >= 8'd32 || y >= 7'd16) oor++;
      else begin
        fb[x[4:0]][y[3:0]] = colour;
        if (r_draw_en === 1'b1) begin
          draw_cnt++;
          wr[x[4:0]][y[3:0]]++;
          if (first_plot_cyc < 0) first_plot_cyc = cyc;
        end else begin
          clear_cnt++;
          if (colour !== 3'd0 || x < 8'd4 || x > 8'd30 || y < 7'd4 || y > 7'd11) clear_bad++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 16; j++) begin
        fb[i][j] = 3'b101;
        wr[i][j] = 0;
      end
    clear_cnt = 0; draw_cnt = 0; clear_bad = 0; oor = 0; pause_bad = 0;
    fin_cnt = 0; busy_cyc = 0; en_cyc = -1; first_plot_cyc = -1;
  endtask

  // Pixels in the 27x8 region that differ from the expected drawing, or were
  // drawn a wrong number of times.
  function automatic int region_errs(input int v);
    int errs = 0;
    int nd = ndig_of(v);
    for (int d = 0; d < 3; d++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 9; c++) begin
          int xx = 4 + 9 * d + c;
          int yy = 4 + r;
          logic [2:0] expc = 3'd0;
          int expw = 0;
          if (d < nd && c < 8) begin
            expc = font_bit(digit_of(v, nd, d), r, 7 - c) ? 3'd7 : 3'd0;
            expw = 1;
          end
          if (xx <= 30 && (fb[xx][yy] !== expc || wr[xx][yy] != expw)) errs++;
        end
    return errs;
  endfunction

  task automatic run_draw(input logic [9:0] sc, input bit rnd, input bit extra_start);
    clr_mon();
    @(posedge clk); #1;
    score = sc; start = 1'b1; bus_grant = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5000 && fin_cnt == 0; i++) begin
      @(posedge clk); #1;
      bus_grant = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = extra_start && (i == 50);
    end
    start = 1'b0;
    bus_grant = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bus_grant = 1'b0; score = '0;
    clr_mon();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ctrl", {finished, r_ld_en, r_draw_en, plot}, 0);
    check("rst_pixel", {x, y, colour}, 0);
    check("rst_pause_lo_grant", r_pause, 1);
    bus_grant = 1'b1;
    #1;
    check("rst_pause_hi_grant", r_pause, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Score 7, grant high.
    run_draw(10'd7, 1'b0, 1'b0);
    check("s7_clear_cnt", clear_cnt, 216);
    check("s7_clear_bad", clear_bad, 0);
    check("s7_draw_cnt", draw_cnt, 64);
    check("s7_region", region_errs(7), 0);
    check("s7_px_5_4", fb[5][4], 7);
    check("s7_px_10_4", fb[10][4], 7);
    check("s7_px_4_4", fb[4][4], 0);
    check("s7_finished", fin_cnt, 1);
    check("s7_busy_after", busy, 0);
    check("s7_busy_cycles", busy_cyc, 284);
    check("s7_first_plot_lat", first_plot_cyc - en_cyc, 1);
    check("s7_oor", oor, 0);

    // Score 123.
    run_draw(10'd123, 1'b0, 1'b0);
    check("s123_draw_cnt", draw_cnt, 192);
    check("s123_region", region_errs(123), 0);
    check("s123_px_7_4", fb[7][4], 7);
    check("s123_px_8_4", fb[8][4], 7);
    check("s123_px_6_4", fb[6][4], 0);
    check("s123_px_24_4", fb[24][4], 7);
    check("s123_px_22_4", fb[22][4], 0);
    check("s123_busy_cycles", busy_cyc, 412);

    // Score 1000 clamps to 999.
    run_draw(10'd1000, 1'b0, 1'b0);
    check("s1000_r_score", r_score, 999);
    check("s1000_draw_cnt", draw_cnt, 192);
    check("s1000_region", region_errs(999), 0);
    check("s1000_px_6_4", fb[6][4], 7);
    check("s1000_px_4_4", fb[4][4], 0);

    // Pseudo-random grant.
    run_draw(10'd123, 1'b1, 1'b0);
    check("rnd_plot_cnt", clear_cnt + draw_cnt, 408);
    check("rnd_clear_bad", clear_bad, 0);
    check("rnd_region", region_errs(123), 0);
    check("rnd_pause", pause_bad, 0);
    check("rnd_finished", fin_cnt, 1);
    check("rnd_oor", oor, 0);

    // Reset in the middle of DRAW.
    clr_mon();
    @(posedge clk); #1;
    score = 10'd45; start = 1'b1; bus_grant = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2000 && draw_cnt < 10; i++) @(posedge clk);
    #1;
    check("mid_reached_draw", draw_cnt >= 10, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_plot", plot, 0);
    check("mid_draw_en", r_draw_en, 0);
    run_draw(10'd45, 1'b0, 1'b0);
    check("mid_redraw_cnt", draw_cnt, 128);
    check("mid_redraw_region", region_errs(45), 0);
    check("mid_redraw_finished", fin_cnt, 1);

    // Start pulsed during CLEAR is ignored.
    run_draw(10'd305, 1'b0, 1'b1);
    check("dbl_finished", fin_cnt, 1);
    check("dbl_region", region_errs(305), 0);
    check("dbl_busy_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
